// File: rtl/masked_random_source_pkg.sv
// Shared constants, types and helper functions for the masked S-box randomness source.
package masked_random_source_pkg;

    localparam int unsigned LFSR_WIDTH = 32;
    // Feedback taps for x^32 + x^22 + x^2 + x + 1: state bits 31, 21, 1, 0.
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic {
        STAGE_HPC1,
        STAGE_HPC3
    } stage_type_t;

    localparam stage_type_t DEFAULT_STAGE_TYPE = STAGE_HPC1;

    typedef enum logic [1:0] {
        SEED,
        WARMUP,
        RUN
    } rng_state_t;

    // Fresh bits one masked Canright inverse consumes per evaluation.
    function automatic int unsigned num_canright_inv_random(input int unsigned shares,
                                                            input stage_type_t stage);
        int unsigned pairs;
        pairs = shares * (shares - 1) / 2;
        return (stage == STAGE_HPC3) ? 36 * pairs : 18 * pairs;
    endfunction

    function automatic int unsigned num_random_lanes(input int unsigned width);
        return (width + LFSR_WIDTH - 1) / LFSR_WIDTH;
    endfunction

    function automatic logic [LFSR_WIDTH-1:0] lfsr32_advance(input logic [LFSR_WIDTH-1:0] state,
                                                             input int unsigned steps);
        logic [LFSR_WIDTH-1:0] s;
        s = state;
        for (int unsigned i = 0; i < steps; i++) begin
            s = {s[LFSR_WIDTH-2:0], ^(s & LFSR_TAPS)};
        end
        return s;
    endfunction

endpackage

// File: rtl/masked_random_source_lane.sv
// One 32-bit Fibonacci LFSR lane: serial seed load, 32-step advance, or hold.
module lfsr32_lane
    import masked_random_source_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [LFSR_WIDTH-1:0] load_data_i,
    input  logic                  advance_i,
    output logic [LFSR_WIDTH-1:0] state_o
);

    logic [LFSR_WIDTH-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            // The all-zero state is a fixed point of the LFSR, so it is never loaded.
            state_d = (load_data_i == '0) ? LFSR_WIDTH'(1) : load_data_i;
        end else if (advance_i) begin
            state_d = lfsr32_advance(state_q, LFSR_WIDTH);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/masked_random_source.sv
// Seeded, warmed-up LFSR bank presenting one never-reused random word per consumer take.
module masked_random_source
    import masked_random_source_pkg::*;
#(
    parameter int unsigned NUM_SHARES    = 2,
    parameter stage_type_t STAGE_TYPE    = DEFAULT_STAGE_TYPE,
    parameter int unsigned OUT_WIDTH     = num_canright_inv_random(NUM_SHARES, STAGE_TYPE),
    parameter int unsigned WARMUP_CYCLES = 16
) (
    input  logic                 in_clock,
    input  logic                 in_reset,
    input  logic [31:0]          in_seed_data,
    input  logic                 in_seed_valid,
    output logic                 out_seed_ready,
    input  logic                 in_reseed,
    output logic [OUT_WIDTH-1:0] out_random,
    output logic                 out_valid,
    input  logic                 in_take
);

    localparam int unsigned NUM_LANES = num_random_lanes(OUT_WIDTH);
    localparam int unsigned IDX_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned CNT_W     = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WARMUP_CYCLES);

    if (WARMUP_CYCLES < 1) begin : g_bad_warmup
        $error("masked_random_source: WARMUP_CYCLES must be at least 1");
    end

    rng_state_t             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   accept;
    logic                   advance;
    logic [NUM_LANES-1:0]   load_lane;
    logic [NUM_LANES*LFSR_WIDTH-1:0] lanes_flat;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        advance = 1'b0;
        unique case (state_q)
            SEED: begin
                if (in_seed_valid) begin
                    accept = 1'b1;
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = WARMUP;
                        idx_d   = '0;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WARMUP: begin
                advance = 1'b1;
                cnt_d   = cnt_q - 1'b1;
                if (in_reseed) begin
                    state_d = SEED;
                    idx_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // A take coinciding with a reseed still consumes the current word.
                advance = in_take;
                if (in_reseed) begin
                    state_d = SEED;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = SEED;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state_q <= SEED;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        load_lane = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            load_lane[i] = accept && (idx_q == IDX_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lfsr32_lane u_lane (
            .clk_i       (in_clock),
            .rst_i       (in_reset),
            .load_i      (load_lane[g]),
            .load_data_i (in_seed_data),
            .advance_i   (advance),
            .state_o     (lanes_flat[g*LFSR_WIDTH +: LFSR_WIDTH])
        );
    end

    if (NUM_LANES * LFSR_WIDTH > OUT_WIDTH) begin : g_tail
        logic unused_tail;
        assign unused_tail = ^lanes_flat[NUM_LANES*LFSR_WIDTH-1:OUT_WIDTH];
    end

    assign out_seed_ready = (state_q == SEED);
    assign out_valid      = (state_q == RUN);
    assign out_random     = out_valid ? lanes_flat[OUT_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_masked_random_source.sv
// Directed bench for masked_random_source with three lanes (80-bit output) and a 4-cycle warm-up.
module tb_masked_random_source;

    localparam int unsigned W  = 4;
    localparam int unsigned OW = 80;

    logic          in_clock = 1'b0;
    logic          in_reset;
    logic [31:0]   in_seed_data;
    logic          in_seed_valid;
    logic          out_seed_ready;
    logic          in_reseed;
    logic [OW-1:0] out_random;
    logic          out_valid;
    logic          in_take;

    int checks = 0;
    int errors = 0;
    logic [31:0] m [3];

    always #5 in_clock = ~in_clock;

    masked_random_source #(
        .OUT_WIDTH     (OW),
        .WARMUP_CYCLES (W)
    ) dut (
        .in_clock       (in_clock),
        .in_reset       (in_reset),
        .in_seed_data   (in_seed_data),
        .in_seed_valid  (in_seed_valid),
        .out_seed_ready (out_seed_ready),
        .in_reseed      (in_reseed),
        .out_random     (out_random),
        .out_valid      (out_valid),
        .in_take        (in_take)
    );

    // Reference advance written as the bit-sequence recurrence a[k] = a[k-32]^a[k-22]^a[k-2]^a[k-1].
    function automatic logic [31:0] ref_adv(input logic [31:0] s);
        logic [63:0] a;
        logic [31:0] r;
        for (int j = 0; j < 32; j++) a[j] = s[31-j];
        for (int j = 32; j < 64; j++) a[j] = a[j-32] ^ a[j-22] ^ a[j-2] ^ a[j-1];
        for (int i = 0; i < 32; i++) r[i] = a[63-i];
        return r;
    endfunction

    function automatic logic [OW-1:0] exp_word();
        return {m[2][15:0], m[1], m[0]};
    endfunction

    task automatic model_seed(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        m[0] = (a == 32'h0) ? 32'h1 : a;
        m[1] = (b == 32'h0) ? 32'h1 : b;
        m[2] = (c == 32'h0) ? 32'h1 : c;
    endtask

    task automatic model_adv(input int n);
        for (int k = 0; k < n; k++)
            for (int l = 0; l < 3; l++) m[l] = ref_adv(m[l]);
    endtask

    task automatic tick();
        @(posedge in_clock);
        #1;
    endtask

    task automatic do_reset();
        in_reset = 1'b1; in_seed_valid = 1'b0; in_seed_data = '0;
        in_reseed = 1'b0; in_take = 1'b0;
        tick(); tick();
        in_reset = 1'b0;
    endtask

    task automatic seed3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        in_seed_valid = 1'b1;
        in_seed_data = a; tick();
        in_seed_data = b; tick();
        in_seed_data = c; tick();
        in_seed_valid = 1'b0;
        in_seed_data = '0;
    endtask

    // k counts cycles after the last accepted seed word; 100 means out_valid never rose.
    task automatic wait_valid(output int k);
        k = 1;
        while (out_valid !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_seed_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", out_seed_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_random !== '0) begin errors++; $display("FAIL reset_random: got %h expected 0", out_random); end
    endtask

    task automatic test_seed_warmup();
        int k;
        do_reset();
        seed3(32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C);
        model_seed(32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C);
        model_adv(W);
        k = 1;
        while (out_valid !== 1'b1 && k < 100) begin
            checks++;
            if (out_random !== '0 || out_seed_ready !== 1'b0) begin
                errors++;
                $display("FAIL warmup_masked: cycle %0d got random %h ready %b expected 0 and 0", k, out_random, out_seed_ready);
            end
            tick();
            k++;
        end
        checks++; if (k !== W + 1) begin errors++; $display("FAIL valid_latency: got %0d expected %0d", k, W + 1); end
        checks++; if (out_random !== exp_word()) begin errors++; $display("FAIL first_word: got %h expected %h", out_random, exp_word()); end
    endtask

    task automatic test_hold_take();
        logic [OW-1:0] prev;
        for (int c = 0; c < 20; c++) begin
            in_take = 1'b0;
            in_seed_valid = (c % 3 == 0);
            in_seed_data = 32'hFFFF_FFFF;
            tick();
            checks++; if (out_random !== exp_word()) begin errors++; $display("FAIL hold_stable: cycle %0d got %h expected %h", c, out_random, exp_word()); end
        end
        in_seed_valid = 1'b0;
        prev = out_random;
        for (int p = 0; p < 5; p++) begin
            in_take = 1'b1; tick();
            in_take = 1'b0;
            model_adv(1);
            checks++; if (out_random !== exp_word()) begin errors++; $display("FAIL take_word: take %0d got %h expected %h", p, out_random, exp_word()); end
            checks++; if (out_random === prev) begin errors++; $display("FAIL take_fresh: take %0d got %h expected a word differing from %h", p, out_random, prev); end
            prev = out_random;
            tick();
            checks++; if (out_random !== exp_word()) begin errors++; $display("FAIL take_gap: take %0d got %h expected %h", p, out_random, exp_word()); end
        end
    endtask

    task automatic test_reseed_take();
        int k;
        in_take = 1'b1; in_reseed = 1'b1; tick();
        in_take = 1'b0; in_reseed = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reseed_valid: got %b expected 0", out_valid); end
        checks++; if (out_seed_ready !== 1'b1) begin errors++; $display("FAIL reseed_ready: got %b expected 1", out_seed_ready); end
        checks++; if (out_random !== '0) begin errors++; $display("FAIL reseed_random: got %h expected 0", out_random); end
        // Reseed requested during warm-up returns to SEED as well.
        seed3(32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003);
        tick();
        in_reseed = 1'b1; tick(); in_reseed = 1'b0;
        checks++; if (out_seed_ready !== 1'b1) begin errors++; $display("FAIL warmup_reseed_ready: got %b expected 1", out_seed_ready); end
        seed3(32'h0BAD_F00D, 32'h1357_9BDF, 32'h2468_ACE0);
        model_seed(32'h0BAD_F00D, 32'h1357_9BDF, 32'h2468_ACE0);
        model_adv(W);
        wait_valid(k);
        checks++; if (k !== W + 1) begin errors++; $display("FAIL reseed_latency: got %0d expected %0d", k, W + 1); end
        checks++; if (out_random !== exp_word()) begin errors++; $display("FAIL reseed_word: got %h expected %h", out_random, exp_word()); end
    endtask

    task automatic test_zero_seed();
        int k;
        int zeros;
        do_reset();
        seed3(32'h0, 32'h0, 32'h0);
        model_seed(32'h1, 32'h1, 32'h1);
        model_adv(W);
        wait_valid(k);
        checks++; if (out_random !== exp_word()) begin errors++; $display("FAIL zero_seed_word: got %h expected %h", out_random, exp_word()); end
        zeros = 0;
        in_take = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            tick();
            model_adv(1);
            if (out_random === '0) zeros++;
            checks++; if (out_random !== exp_word()) begin errors++; $display("FAIL zero_seed_take: take %0d got %h expected %h", t, out_random, exp_word()); end
        end
        in_take = 1'b0;
        checks++; if (zeros !== 0) begin errors++; $display("FAIL zero_seed_nonzero: got %0d zero words expected 0", zeros); end
    endtask

    task automatic test_reset_mid_seed();
        int k;
        do_reset();
        in_seed_valid = 1'b1; in_seed_data = 32'hDEADBEEF; tick();
        in_seed_valid = 1'b0;
        in_reset = 1'b1; tick(); in_reset = 1'b0;
        checks++; if (out_seed_ready !== 1'b1) begin errors++; $display("FAIL midseed_ready: got %b expected 1", out_seed_ready); end
        // Reset during warm-up discards it too.
        seed3(32'h11111111, 32'h22222222, 32'h33333333);
        tick();
        in_reset = 1'b1; tick(); in_reset = 1'b0;
        checks++; if (out_seed_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL midwarm_state: got ready %b valid %b expected 1 0", out_seed_ready, out_valid); end
        seed3(32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C);
        model_seed(32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C);
        model_adv(W);
        wait_valid(k);
        checks++; if (k !== W + 1) begin errors++; $display("FAIL midseed_latency: got %0d expected %0d", k, W + 1); end
        for (int t = 0; t < 3; t++) begin
            checks++; if (out_random !== exp_word()) begin errors++; $display("FAIL midseed_word: take %0d got %h expected %h", t, out_random, exp_word()); end
            in_take = 1'b1; tick(); in_take = 1'b0;
            model_adv(1);
        end
    endtask

    task automatic test_gappy_seed();
        int k;
        do_reset();
        in_take = 1'b1;
        in_seed_valid = 1'b1; in_seed_data = 32'hCAFEBABE; tick();
        in_seed_valid = 1'b0; in_seed_data = 32'h55555555; tick(); tick();
        in_reseed = 1'b1; tick(); in_reseed = 1'b0;
        checks++; if (out_seed_ready !== 1'b1) begin errors++; $display("FAIL gap_ready: got %b expected 1", out_seed_ready); end
        in_seed_valid = 1'b1; in_seed_data = 32'h00C0FFEE; tick();
        in_seed_valid = 1'b0; in_seed_data = 32'h77777777; in_reseed = 1'b1; tick();
        in_reseed = 1'b0;
        in_seed_valid = 1'b1; in_seed_data = 32'h8BADF00D; tick();
        in_seed_valid = 1'b0; in_seed_data = '0;
        model_seed(32'hCAFEBABE, 32'h00C0FFEE, 32'h8BADF00D);
        model_adv(W);
        wait_valid(k);
        in_take = 1'b0;
        checks++; if (k !== W + 1) begin errors++; $display("FAIL gap_latency: got %0d expected %0d", k, W + 1); end
        checks++; if (out_random !== exp_word()) begin errors++; $display("FAIL gap_word: got %h expected %h", out_random, exp_word()); end
    endtask

    initial begin
        test_reset();
        test_seed_warmup();
        test_hold_take();
        test_reseed_take();
        test_zero_seed();
        test_reset_mid_seed();
        test_gappy_seed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/masked_random_source.md
Name: masked_random_source

Overview:
- Fresh-randomness producer: the transmit end of the `in_random` interface that masked S-box datapaths consume, e.g. the Canright GF(2^8) inverse.
- Holds a bank of 32-bit maximal-length LFSR lanes, seeded serially through a valid/ready handshake and warmed up before use.
- Presents one never-reused random word per consumer take.
- Sits between the key/seed interface and each masked S-box instance in the AES round.

Parameters:
- NUM_SHARES, 2, share count of the consuming masked S-box.
- STAGE_TYPE, DEFAULT_STAGE_TYPE, stage-4 gadget flavour of the consumer (HPC1/HPC3).
- OUT_WIDTH, num_canright_inv_random(NUM_SHARES, STAGE_TYPE), random bits delivered per take.
- WARMUP_CYCLES, 16, LFSR advances discarded after seeding; must be >= 1 (elaboration $error otherwise).
- NUM_LANES (localparam), ceil(OUT_WIDTH/32), number of LFSR lanes.

Ports:
- in_clock  input  1  clock
- in_reset  input  1  synchronous, active-high reset
- in_seed_data  input  32  seed word for the current lane
- in_seed_valid  input  1  seed word present
- out_seed_ready  output  1  block accepts a seed word
- in_reseed  input  1  request a new seeding sequence
- out_random  output  OUT_WIDTH  random word to the consumer
- out_valid  output  1  out_random is fresh
- in_take  input  1  consumer uses out_random this cycle

Behaviour:
- Clocking: one clock; reset is synchronous and active-high, named in_clock/in_reset as elsewhere in the codebase.
- Lane step: Fibonacci LFSR, taps x^32+x^22+x^2+x+1.
  - fb = s[31]^s[21]^s[1]^s[0]; next = {s[30:0], fb}.
  - One "advance" = 32 unrolled steps, so all 32 bits of a lane are replaced.
  - Example: one step from 0x00000001 gives 0x00000003.
- out_random = lane states concatenated (lane 0 in LSBs), truncated to OUT_WIDTH.
- out_random is forced to all-zero whenever out_valid=0, so seed and warm-up state never appear on the port.
- FSM states:
  - SEED: out_seed_ready=1.
    - Each accepted word (in_seed_valid & out_seed_ready) loads lane[idx] and increments idx.
    - A zero word is loaded as 0x00000001 to prevent lockup.
    - Acceptance with idx=NUM_LANES-1 moves to WARMUP and sets cnt=WARMUP_CYCLES.
  - WARMUP: all lanes advance every cycle; cnt decrements; cnt reaching 1 on a clock edge moves to RUN.
  - RUN: out_valid=1.
    - All lanes advance on a cycle with in_take=1; otherwise they hold.
    - A word is therefore never presented twice after a take.
- Latency: out_valid rises exactly WARMUP_CYCLES+1 cycles after the cycle the last seed word is accepted.
- Reset: next state SEED, idx=0, cnt=0, all lanes 0.
  - Outputs after reset: out_seed_ready=1, out_valid=0, out_random=0.
  - Reset mid-SEED or mid-WARMUP discards partial progress.
- in_reseed:
  - Honoured in WARMUP and RUN: next state SEED, idx=0; out_valid=0 from the following cycle.
  - Ignored in SEED; no restart of idx.
- in_reseed and in_take in the same RUN cycle: the take completes (lanes advance), then the FSM enters SEED.
- in_take while out_valid=0 has no effect.
- in_seed_valid outside SEED is ignored.

Decomposition:
- Shared package (aes128_package) additions:
  - LFSR_WIDTH=32 and LFSR_TAPS constants.
  - function lfsr32_advance(state, steps).
  - function num_random_lanes(width).
  - enum rng_state_t {SEED, WARMUP, RUN}.
- One natural sub-module, lfsr32_lane (load, advance, hold), instantiated NUM_LANES times in a generate loop.
- State and counters use the existing register module.

Test Plan:
- Reset then seed words 0x12345678, 0x9ABCDEF0, … (NUM_LANES words, back-to-back valid), WARMUP_CYCLES=4, last word accepted at cycle 10 -> out_valid rises at cycle 15; out_random is 0 before that and matches the package-function model after.
- All seed words 0x00000000 -> lane sequence identical to seeding 0x00000001; out_random never stays 0 over 1000 takes.
- in_take held low for 20 cycles in RUN -> out_random stable; in_take pulsed 5 times -> 5 distinct words matching the model, no repeats.
- in_reseed together with in_take at cycle t in RUN -> out_valid=0 at t+1, out_seed_ready=1 at t+1, the word from cycle t counted as consumed.
- in_reset asserted after 1 of NUM_LANES seed words -> idx restarts at 0; a full reseed yields a sequence identical to a clean-reset run with the same seeds.
- Seed valid toggling 1,0,1 with gaps, plus in_reseed pulsed during SEED -> only words with valid&ready are loaded; idx is unaffected by in_reseed.
